// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage CPU.
// Combinational stall/flush decode by fixed priority (memory freeze, redirect, load-use,
// interrupt FSM), plus a registered drain/inject FSM for interrupt entry.
module hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] id_rs1,
    input  logic [3:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [3:0] ex_reg_dst,
    input  logic       ex_reg_wr,
    input  logic       ex_wb_sel,
    input  logic       ex_redirect,
    input  logic       ex_returni,
    input  logic       dmem_rdy,
    input  logic       irq,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_stall,
    output logic       id_ex_flush,
    output logic       ex_mem_stall,
    output logic       int_inject,
    output logic       irq_ack,
    output logic       in_isr
);

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StInject,
        StIsr
    } state_e;

    localparam logic [CNT_W-1:0] DrainLoad = CNT_W'(DRAIN_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_ack_q, irq_ack_d;
    logic             in_isr_q, in_isr_d;
    logic             load_use;

    // A load in EX feeding a register read in ID; r0 is hardwired and never a source.
    assign load_use = ex_wb_sel && ex_reg_wr && (ex_reg_dst != 4'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_reg_dst)) ||
                       (id_rs2_used && (id_rs2 == ex_reg_dst)));

    // Priority decode of pipeline controls and FSM next state.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        int_inject   = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        irq_ack_d    = 1'b0;
        in_isr_d     = in_isr_q;

        if (!dmem_rdy) begin
            // Whole pipe frozen; FSM holds so drain timing resumes intact.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            // Redirect injects fresh instructions; restart the drain window.
            if (state_q == StDrain) begin
                cnt_d = DrainLoad;
            end
            if ((state_q == StIsr) && ex_returni) begin
                state_d  = StIdle;
                in_isr_d = 1'b0;
            end
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (irq && !in_isr_q) begin
                        state_d = StDrain;
                        cnt_d   = DrainLoad;
                    end
                end
                StDrain: begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    cnt_d       = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StInject;
                    end
                end
                StInject: begin
                    int_inject  = 1'b1;
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    irq_ack_d   = 1'b1;
                    in_isr_d    = 1'b1;
                    state_d     = StIsr;
                end
                StIsr: begin
                    // Handler runs; irq ignored until returni.
                end
            endcase
        end
    end

    // FSM state, drain counter and registered interrupt outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            irq_ack_q <= 1'b0;
            in_isr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            irq_ack_q <= irq_ack_d;
            in_isr_q  <= in_isr_d;
        end
    end

    assign irq_ack = irq_ack_q;
    assign in_isr  = in_isr_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle comparison against a behavioural model
// plus literal expectations at the interesting cycles.
module tb_hazard_ctrl;

    localparam int DRAIN = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] id_rs1, id_rs2, ex_reg_dst;
    logic       id_rs1_used, id_rs2_used, ex_reg_wr, ex_wb_sel;
    logic       ex_redirect, ex_returni, dmem_rdy, irq;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic       ex_mem_stall, int_inject, irq_ack, in_isr;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(
        .DRAIN_CYCLES(DRAIN),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_reg_dst  (ex_reg_dst),
        .ex_reg_wr   (ex_reg_wr),
        .ex_wb_sel   (ex_wb_sel),
        .ex_redirect (ex_redirect),
        .ex_returni  (ex_returni),
        .dmem_rdy    (dmem_rdy),
        .irq         (irq),
        .pc_stall    (pc_stall),
        .if_id_stall (if_id_stall),
        .if_id_flush (if_id_flush),
        .id_ex_stall (id_ex_stall),
        .id_ex_flush (id_ex_flush),
        .ex_mem_stall(ex_mem_stall),
        .int_inject  (int_inject),
        .irq_ack     (irq_ack),
        .in_isr      (in_isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic int_inject;
        logic irq_ack;
        logic in_isr;
    } outs_t;

    // Model: drain bubbles still owed, an inject slot pending, handler active, ack pulse.
    typedef struct packed {
        int   left;
        logic inj;
        logic isr;
        logic ack;
    } m_t;

    m_t m;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, required %b", name, $time, act, exp);
        end
    endtask

    function automatic logic hazard();
        if (!(ex_wb_sel && ex_reg_wr) || ex_reg_dst == 0) return 1'b0;
        return (id_rs1_used && id_rs1 == ex_reg_dst) || (id_rs2_used && id_rs2 == ex_reg_dst);
    endfunction

    function automatic outs_t model_out(m_t s);
        outs_t o;
        o = '0;
        if (!dmem_rdy) begin
            o.pc_stall = 1; o.if_id_stall = 1; o.id_ex_stall = 1; o.ex_mem_stall = 1;
        end else if (ex_redirect) begin
            o.if_id_flush = 1; o.id_ex_flush = 1;
        end else if (hazard() || s.left > 0) begin
            o.pc_stall = 1; o.if_id_stall = 1; o.id_ex_flush = 1;
        end else if (s.inj) begin
            o.int_inject = 1; o.pc_stall = 1; o.if_id_stall = 1;
        end
        o.irq_ack = s.ack;
        o.in_isr  = s.isr;
        return o;
    endfunction

    function automatic m_t model_next(m_t s);
        m_t n;
        n = s;
        n.ack = 0;
        if (!dmem_rdy) return n;
        if (ex_redirect) begin
            if (s.left > 0) n.left = DRAIN;
            if (s.isr && ex_returni) n.isr = 0;
        end else if (hazard()) begin
            // bubble only
        end else if (s.left > 0) begin
            n.left = s.left - 1;
            if (n.left == 0) n.inj = 1;
        end else if (s.inj) begin
            n.inj = 0; n.isr = 1; n.ack = 1;
        end else if (!s.isr && irq) begin
            n.left = DRAIN;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m);
    end

    // Every cycle the full output vector must match the model.
    always @(negedge clk) begin
        chk("cycle", {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                      ex_mem_stall, int_inject, irq_ack, in_isr}, model_out(m));
    end

    task automatic idle_in();
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_reg_dst = 0; ex_reg_wr = 0; ex_wb_sel = 0;
        ex_redirect = 0; ex_returni = 0; dmem_rdy = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_in(input logic [3:0] dst, input logic [3:0] rs1, input logic [3:0] rs2,
                           input logic u1, input logic u2);
        ex_wb_sel = 1; ex_reg_wr = 1; ex_reg_dst = dst;
        id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
    endtask

    initial begin
        idle_in();
        irq   = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_isr", in_isr, 0);
        chk("rst_irq_ack", irq_ack, 0);
        chk("rst_pc_stall", pc_stall, 0);
        @(negedge clk);
        #2 rst_n = 1;
        tick();

        // Load-use on rs1: one bubble, then clear.
        load_in(4'd3, 4'd3, 4'd0, 1, 0);
        #1 chk("lu_pc_stall", pc_stall, 1);
        chk("lu_if_id_stall", if_id_stall, 1);
        chk("lu_id_ex_flush", id_ex_flush, 1);
        tick();
        idle_in();
        #1 chk("lu_after", {pc_stall, id_ex_flush}, 0);
        tick();
        // rs2 match, rs2 match without use, r0, non-load.
        load_in(4'd5, 4'd1, 4'd5, 1, 1);
        #1 chk("lu_rs2", pc_stall, 1);
        tick();
        load_in(4'd5, 4'd1, 4'd5, 1, 0);
        #1 chk("lu_rs2_unused", pc_stall, 0);
        tick();
        load_in(4'd0, 4'd0, 4'd0, 1, 1);
        #1 chk("lu_r0", id_ex_flush, 0);
        tick();
        load_in(4'd7, 4'd7, 4'd0, 1, 0);
        ex_wb_sel = 0;
        #1 chk("alu_no_stall", pc_stall, 0);
        tick();
        idle_in();
        tick();

        // Memory freeze over a load-use for 3 cycles, bubble on the 4th.
        load_in(4'd3, 4'd3, 4'd0, 1, 0);
        dmem_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("frz_ex_mem_stall", ex_mem_stall, 1);
            chk("frz_no_flush", {if_id_flush, id_ex_flush}, 0);
            tick();
        end
        dmem_rdy = 1;
        #1 chk("frz_then_bubble", {id_ex_flush, id_ex_stall, ex_mem_stall}, 3'b100);
        tick();
        idle_in();
        tick();

        // Redirect pulses: alone, with r0 load, with a real hazard.
        ex_redirect = 1;
        #1 chk("redir_flush", {if_id_flush, id_ex_flush, pc_stall}, 3'b110);
        tick();
        ex_redirect = 0;
        #1 chk("redir_once", if_id_flush, 0);
        tick();
        load_in(4'd0, 4'd0, 4'd0, 1, 0);
        ex_redirect = 1;
        #1 chk("redir_r0", {if_id_flush, pc_stall, if_id_stall}, 3'b100);
        tick();
        load_in(4'd4, 4'd4, 4'd0, 1, 0);
        ex_redirect = 1;
        #1 chk("redir_over_lu", {if_id_flush, pc_stall}, 2'b10);
        tick();
        idle_in();
        tick();

        // Interrupt entry; irq drops during drain but entry completes.
        irq = 1;
        #1 chk("irq_no_bubble_yet", id_ex_flush, 0);
        tick();
        irq = 0;
        #1 chk("drain1", {pc_stall, id_ex_flush}, 2'b11);
        tick();
        #1 chk("drain2", {id_ex_flush, int_inject}, 2'b10);
        tick();
        #1 chk("inject", {int_inject, id_ex_flush, irq_ack}, 3'b100);
        tick();
        irq = 1;
        #1 chk("ack_isr", {irq_ack, in_isr}, 2'b11);
        tick();
        #1 chk("ack_pulse", {irq_ack, in_isr, pc_stall}, 3'b010);
        tick();
        tick();
        irq = 0;
        ex_redirect = 1; ex_returni = 1;
        #1 chk("reti_cycle", {if_id_flush, in_isr}, 2'b11);
        tick();
        idle_in();
        #1 chk("reti_exit", in_isr, 0);
        tick();

        // Redirect during drain reloads counter; freeze holds it.
        irq = 1;
        tick();
        irq = 0;
        ex_redirect = 1;
        #1 chk("drain_redir", {if_id_flush, pc_stall}, 2'b10);
        tick();
        ex_redirect = 0;
        #1 chk("drain_reload1", id_ex_flush, 1);
        tick();
        dmem_rdy = 0;
        #1 chk("drain_frz", {ex_mem_stall, id_ex_flush, int_inject}, 3'b100);
        tick();
        dmem_rdy = 1;
        #1 chk("drain_reload2", {id_ex_flush, int_inject}, 2'b10);
        tick();
        #1 chk("inject_late", int_inject, 1);
        tick();
        #1 chk("ack_late", irq_ack, 1);
        ex_redirect = 1; ex_returni = 1;
        tick();
        idle_in();
        tick();

        // Reset mid-drain, then full restart with irq held.
        irq = 1;
        tick();
        rst_n = 0;
        #1 chk("rst_mid", {irq_ack, in_isr, id_ex_flush, pc_stall}, 0);
        @(negedge clk);
        #2 rst_n = 1;
        tick();
        #1 chk("restart_drain", id_ex_flush, 1);
        tick();
        tick();
        #1 chk("restart_inject", int_inject, 1);
        tick();
        irq = 0;
        #1 chk("restart_ack", {irq_ack, in_isr}, 2'b11);
        ex_redirect = 1; ex_returni = 1;
        tick();
        idle_in();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
